fpu_exc_resolve: RTL and testbench

Downstream neighbour of the operand exception-detect stage in the single-precision FPU pipeline. Consumes the registered special-operand flags, delays the matching opcode and operand signs to line up with them, and selects the final IEEE-754 result: canonical QNaN, signed infinity, signed zero, or the arithmetic core result. Each result is registered and its exception bits are accumulated into a sticky status register. The block is fully pipelined, accepts one operation per cycle, and has no backpressure.

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fpu_delay_line.sv | 36 +++
 rtl/fpu_exc_resolve.sv | 157 +++++++++++++++
 tb/tb_fpu_exc_resolve.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// +--------------------------------------------------------------------+
// | fpu_pkg : shared opcode, result and exception-bit definitions       |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package fpu_pkg;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2,
      DIV = 2'd3
   } fpu_op_e;

   localparam logic [31:0] QNAN_CANON = 32'h7FC00000;

   // Bit positions inside the {NV,DZ,OF,UF,NX} exception vector
   localparam int EXC_NV = 4;
   localparam int EXC_DZ = 3;
   localparam int EXC_OF = 2;
   localparam int EXC_UF = 1;
   localparam int EXC_NX = 0;

   typedef logic [4:0] exc_t;

   function automatic logic [31:0] signed_inf(input logic sgn);
      return {sgn, 8'hFF, 23'd0};
   endfunction

   function automatic logic [31:0] signed_zero(input logic sgn);
      return {sgn, 31'd0};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_delay_line.sv
// +--------------------------------------------------------------------+
// | fpu_delay_line : DEPTH-stage register pipe, async active-low reset  |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module fpu_delay_line #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/fpu_exc_resolve.sv
// +--------------------------------------------------------------------+
// | fpu_exc_resolve : aligns op/signs with special-operand flags and    |
// | selects the final IEEE-754 result plus sticky exception status.     |
// | Optional exception counter: define FPU_EXC_CNT_EN.                  |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module fpu_exc_resolve
   import fpu_pkg::*;
#(
   parameter int EXC_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [1:0]       fpu_op,
   input  logic             opa_sign,
   input  logic             opb_sign,
   input  logic             inf,
   input  logic             ind,
   input  logic             qnan,
   input  logic             snan,
   input  logic             opa_nan,
   input  logic             opb_nan,
   input  logic             opa_00,
   input  logic             opb_00,
   input  logic             opa_inf,
   input  logic             opb_inf,
   input  logic [31:0]      res_in,
   input  logic             res_ovf,
   input  logic             res_unf,
   input  logic             res_ixt,
   input  logic             clr_status,
   output logic             out_valid,
   output logic [31:0]      out_res,
   output logic [4:0]       out_exc,
   output logic [4:0]       status,
   output logic [CNT_W-1:0] exc_cnt
);

   localparam int DL_W = 5;

   logic [DL_W-1:0] w_dl_in;
   logic [DL_W-1:0] w_dl_out;
   logic            w_valid;
   fpu_op_e         w_op;
   logic            w_sa;
   logic            w_sb;
   logic            w_sx;
   logic            w_sb_eff;
   logic            w_addsub;
   logic            w_eff_sub;
   logic [31:0]     w_res;
   exc_t            w_exc;
   exc_t            w_exc_ev;
   logic            w_unused;

   assign w_dl_in = {op_valid, fpu_op, opa_sign, opb_sign};

   fpu_delay_line #(
      .WIDTH (DL_W),
      .DEPTH (EXC_LAT)
   ) u_op_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (w_dl_in),
      .dout  (w_dl_out)
   );

   assign w_valid = w_dl_out[4];
   assign w_op    = fpu_op_e'(w_dl_out[3:2]);
   assign w_sa    = w_dl_out[1];
   assign w_sb    = w_dl_out[0];

   // A quiet NaN needs no action beyond the opa_nan/opb_nan canonicalisation
   assign w_unused = qnan;

   assign w_sx      = w_sa ^ w_sb;
   assign w_sb_eff  = w_sb ^ (w_op == SUB);
   assign w_addsub  = (w_op == ADD) || (w_op == SUB);
   assign w_eff_sub = (w_sa != w_sb_eff);

   always_comb begin
      w_res = res_in;
      w_exc = '0;
      if (opa_nan || opb_nan) begin
         w_res         = QNAN_CANON;
         w_exc[EXC_NV] = snan;
      end else if (w_addsub && ind && w_eff_sub) begin
         w_res         = QNAN_CANON;
         w_exc[EXC_NV] = 1'b1;
      end else if (w_addsub && inf) begin
         w_res = signed_inf(opa_inf ? w_sa : w_sb_eff);
      end else if ((w_op == MUL) && ((opa_inf && opb_00) || (opb_inf && opa_00))) begin
         w_res         = QNAN_CANON;
         w_exc[EXC_NV] = 1'b1;
      end else if ((w_op == MUL) && inf) begin
         w_res = signed_inf(w_sx);
      end else if ((w_op == DIV) && (ind || (opa_00 && opb_00))) begin
         w_res         = QNAN_CANON;
         w_exc[EXC_NV] = 1'b1;
      end else if ((w_op == DIV) && opa_inf) begin
         w_res = signed_inf(w_sx);
      end else if ((w_op == DIV) && opb_inf) begin
         w_res = signed_zero(w_sx);
      end else if ((w_op == DIV) && opb_00) begin
         w_res         = signed_inf(w_sx);
         w_exc[EXC_DZ] = 1'b1;
      end else begin
         w_exc[EXC_OF] = res_ovf;
         w_exc[EXC_UF] = res_unf;
         w_exc[EXC_NX] = res_ixt;
      end
   end

   assign w_exc_ev = w_valid ? w_exc : '0;

   // Status lands on the same edge as the result it reflects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_res   <= '0;
         out_exc   <= '0;
         status    <= '0;
      end else begin
         out_valid <= w_valid;
         if (w_valid) begin
            out_res <= w_res;
            out_exc <= w_exc;
         end
         status <= (clr_status ? 5'd0 : status) | w_exc_ev;
      end
   end

`ifdef FPU_EXC_CNT_EN
   logic [CNT_W-1:0] w_cnt_base;

   assign w_cnt_base = clr_status ? '0 : exc_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_cnt <= '0;
      end else if ((|w_exc_ev) && !(&w_cnt_base)) begin
         exc_cnt <= w_cnt_base + CNT_W'(1);
      end else begin
         exc_cnt <= w_cnt_base;
      end
   end
`else
   assign exc_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_exc_resolve.sv
// +--------------------------------------------------------------------+
// | tb_fpu_exc_resolve : directed self-checking bench for fpu_exc_resolve|
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fpu_exc_resolve;

   localparam int LAT = 2;

   localparam logic [9:0] F_INF  = 10'h200;
   localparam logic [9:0] F_IND  = 10'h100;
   localparam logic [9:0] F_QNAN = 10'h080;
   localparam logic [9:0] F_SNAN = 10'h040;
   localparam logic [9:0] F_ANAN = 10'h020;
   localparam logic [9:0] F_BNAN = 10'h010;
   localparam logic [9:0] F_A00  = 10'h008;
   localparam logic [9:0] F_B00  = 10'h004;
   localparam logic [9:0] F_AINF = 10'h002;
   localparam logic [9:0] F_BINF = 10'h001;

   typedef struct packed {
      logic [1:0]  op;
      logic        sa;
      logic        sb;
      logic [9:0]  f;
      logic [31:0] r;
      logic [2:0]  oux;
      logic [31:0] er;
      logic [4:0]  ee;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_valid;
   logic [1:0]  fpu_op;
   logic        opa_sign, opb_sign;
   logic        inf, ind, qnan, snan, opa_nan, opb_nan, opa_00, opb_00, opa_inf, opb_inf;
   logic [31:0] res_in;
   logic        res_ovf, res_unf, res_ixt;
   logic        clr_status;
   logic        out_valid;
   logic [31:0] out_res;
   logic [4:0]  out_exc;
   logic [4:0]  status;
   logic [15:0] exc_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fpu_exc_resolve #(.EXC_LAT(LAT), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .fpu_op(fpu_op),
      .opa_sign(opa_sign), .opb_sign(opb_sign),
      .inf(inf), .ind(ind), .qnan(qnan), .snan(snan),
      .opa_nan(opa_nan), .opb_nan(opb_nan), .opa_00(opa_00), .opb_00(opb_00),
      .opa_inf(opa_inf), .opb_inf(opb_inf),
      .res_in(res_in), .res_ovf(res_ovf), .res_unf(res_unf), .res_ixt(res_ixt),
      .clr_status(clr_status), .out_valid(out_valid), .out_res(out_res),
      .out_exc(out_exc), .status(status), .exc_cnt(exc_cnt)
   );

   function automatic logic [15:0] cnt_exp(input int n);
`ifdef FPU_EXC_CNT_EN
      return n[15:0];
`else
      return 16'd0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic [9:0] f, input logic [31:0] r, input logic [2:0] oux);
      {inf, ind, qnan, snan, opa_nan, opb_nan, opa_00, opb_00, opa_inf, opb_inf} = f;
      res_in = r;
      {res_ovf, res_unf, res_ixt} = oux;
   endtask

   // Issues one op, presents its flags LAT cycles later, and returns in the result cycle
   task automatic issue_single(input logic [1:0] op, input logic sa, input logic sb,
                               input logic [9:0] f, input logic [31:0] r,
                               input logic [2:0] oux, input logic clr);
      op_valid = 1'b1; fpu_op = op; opa_sign = sa; opb_sign = sb;
      step();
      op_valid = 1'b0; fpu_op = 2'd0; opa_sign = 1'b0; opb_sign = 1'b0;
      for (int i = 1; i < LAT; i++) step();
      set_flags(f, r, oux);
      clr_status = clr;
      step();
      set_flags(10'd0, 32'd0, 3'd0);
      clr_status = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; op_valid = 1'b0; fpu_op = 2'd0; opa_sign = 1'b0; opb_sign = 1'b0;
      clr_status = 1'b0;
      set_flags(10'd0, 32'd0, 3'd0);
      step(); step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      tests++; if (out_res !== 32'd0) begin fails++; $display("FAIL reset_res: got %h want 0", out_res); end
      tests++; if (out_exc !== 5'd0) begin fails++; $display("FAIL reset_exc: got %b want 0", out_exc); end
      tests++; if (status !== 5'd0) begin fails++; $display("FAIL reset_status: got %b want 0", status); end
      tests++; if (exc_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", exc_cnt); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_resolve();
      vec_t       v [19];
      logic [4:0] exp_status;
      int         exp_n;
      exp_status = 5'd0;
      exp_n      = 0;
      //          op     sa    sb    flags                          res_in        oux     expected res  exc
      v[0]  = '{2'd2, 1'b0, 1'b0, F_AINF|F_B00|F_INF,           32'h0BADF00D, 3'b000, 32'h7FC00000, 5'b10000};
      v[1]  = '{2'd3, 1'b1, 1'b0, F_B00,                        32'h0BADF00D, 3'b000, 32'hFF800000, 5'b01000};
      v[2]  = '{2'd1, 1'b0, 1'b0, F_IND|F_INF|F_AINF|F_BINF,    32'h0BADF00D, 3'b000, 32'h7FC00000, 5'b10000};
      v[3]  = '{2'd0, 1'b0, 1'b0, F_IND|F_INF|F_AINF|F_BINF,    32'h0BADF00D, 3'b000, 32'h7F800000, 5'b00000};
      v[4]  = '{2'd1, 1'b0, 1'b0, F_INF|F_BINF,                 32'h0BADF00D, 3'b000, 32'hFF800000, 5'b00000};
      v[5]  = '{2'd0, 1'b1, 1'b0, F_INF|F_AINF,                 32'h0BADF00D, 3'b000, 32'hFF800000, 5'b00000};
      v[6]  = '{2'd0, 1'b0, 1'b0, F_SNAN|F_ANAN,                32'h0BADF00D, 3'b111, 32'h7FC00000, 5'b10000};
      v[7]  = '{2'd2, 1'b0, 1'b0, F_QNAN|F_BNAN,                32'h0BADF00D, 3'b000, 32'h7FC00000, 5'b00000};
      v[8]  = '{2'd2, 1'b1, 1'b0, F_INF|F_AINF,                 32'h0BADF00D, 3'b000, 32'hFF800000, 5'b00000};
      v[9]  = '{2'd2, 1'b0, 1'b1, F_INF|F_BINF|F_A00,           32'h0BADF00D, 3'b000, 32'h7FC00000, 5'b10000};
      v[10] = '{2'd3, 1'b0, 1'b0, F_IND|F_INF|F_AINF|F_BINF,    32'h0BADF00D, 3'b000, 32'h7FC00000, 5'b10000};
      v[11] = '{2'd3, 1'b1, 1'b0, F_A00|F_B00,                  32'h0BADF00D, 3'b000, 32'h7FC00000, 5'b10000};
      v[12] = '{2'd3, 1'b1, 1'b0, F_INF|F_AINF,                 32'h0BADF00D, 3'b000, 32'hFF800000, 5'b00000};
      v[13] = '{2'd3, 1'b0, 1'b1, F_INF|F_BINF,                 32'h0BADF00D, 3'b000, 32'h80000000, 5'b00000};
      v[14] = '{2'd3, 1'b0, 1'b1, F_A00|F_INF|F_BINF,           32'h0BADF00D, 3'b000, 32'h80000000, 5'b00000};
      v[15] = '{2'd2, 1'b0, 1'b0, 10'd0,                        32'h7F800000, 3'b101, 32'h7F800000, 5'b00101};
      v[16] = '{2'd0, 1'b0, 1'b1, 10'd0,                        32'h40490FDB, 3'b000, 32'h40490FDB, 5'b00000};
      v[17] = '{2'd3, 1'b0, 1'b0, 10'd0,                        32'h00000001, 3'b011, 32'h00000001, 5'b00011};
      v[18] = '{2'd1, 1'b0, 1'b1, F_INF|F_AINF,                 32'h0BADF00D, 3'b111, 32'h7F800000, 5'b00000};
      for (int i = 0; i < 19; i++) begin
         issue_single(v[i].op, v[i].sa, v[i].sb, v[i].f, v[i].r, v[i].oux, 1'b0);
         exp_status |= v[i].ee;
         if (v[i].ee != 5'd0) exp_n++;
         tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL resolve%0d_valid: got %b want 1", i, out_valid); end
         tests++; if (out_res !== v[i].er) begin fails++; $display("FAIL resolve%0d_res: got %h want %h", i, out_res, v[i].er); end
         tests++; if (out_exc !== v[i].ee) begin fails++; $display("FAIL resolve%0d_exc: got %b want %b", i, out_exc, v[i].ee); end
         tests++; if (status !== exp_status) begin fails++; $display("FAIL resolve%0d_status: got %b want %b", i, status, exp_status); end
         tests++; if (exc_cnt !== cnt_exp(exp_n)) begin fails++; $display("FAIL resolve%0d_cnt: got %0d want %0d", i, exc_cnt, cnt_exp(exp_n)); end
         step();
         tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL resolve%0d_pulse: got %b want 0", i, out_valid); end
         tests++; if (out_res !== v[i].er) begin fails++; $display("FAIL resolve%0d_hold: got %h want %h", i, out_res, v[i].er); end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      int   pulses;
      pulses = 0;
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
      tests++; if (status !== 5'd0) begin fails++; $display("FAIL b2b_clear_status: got %b want 0", status); end
      tests++; if (exc_cnt !== 16'd0) begin fails++; $display("FAIL b2b_clear_cnt: got %0d want 0", exc_cnt); end
      for (int c = 0; c < 9; c++) begin
         exp_v = (c >= LAT + 1) && (c <= LAT + 4);
         if (out_valid === 1'b1) pulses++;
         tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL b2b_valid_c%0d: got %b want %b", c, out_valid, exp_v); end
         if (exp_v) begin
            tests++; if (out_res !== 32'h3FC00000) begin fails++; $display("FAIL b2b_res_c%0d: got %h want 3fc00000", c, out_res); end
            tests++; if (out_exc !== 5'b00001) begin fails++; $display("FAIL b2b_exc_c%0d: got %b want 00001", c, out_exc); end
         end
         op_valid = (c < 4); fpu_op = 2'd0; opa_sign = 1'b0; opb_sign = 1'b0;
         if (c >= LAT && c < LAT + 4) set_flags(10'd0, 32'h3FC00000, 3'b001);
         else set_flags(10'd0, 32'd0, 3'd0);
         step();
      end
      op_valid = 1'b0;
      tests++; if (pulses != 4) begin fails++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
      tests++; if (status !== 5'b00001) begin fails++; $display("FAIL b2b_status: got %b want 00001", status); end
      tests++; if (exc_cnt !== cnt_exp(4)) begin fails++; $display("FAIL b2b_cnt: got %0d want %0d", exc_cnt, cnt_exp(4)); end
   endtask

   // Clear arrives on the edge that registers a DZ result: the event must survive
   task automatic test_clear_with_event();
      issue_single(2'd3, 1'b0, 1'b0, F_B00, 32'h0BADF00D, 3'b000, 1'b1);
      tests++; if (out_exc !== 5'b01000) begin fails++; $display("FAIL clr_exc: got %b want 01000", out_exc); end
      tests++; if (out_res !== 32'h7F800000) begin fails++; $display("FAIL clr_res: got %h want 7f800000", out_res); end
      tests++; if (status !== 5'b01000) begin fails++; $display("FAIL clr_status: got %b want 01000", status); end
      tests++; if (exc_cnt !== cnt_exp(1)) begin fails++; $display("FAIL clr_cnt: got %0d want %0d", exc_cnt, cnt_exp(1)); end
   endtask

   task automatic test_flags_ignored();
      set_flags(F_SNAN|F_ANAN|F_B00, 32'hDEADBEEF, 3'b111);
      for (int c = 0; c < 3; c++) begin
         step();
         tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ign_valid_c%0d: got %b want 0", c, out_valid); end
      end
      set_flags(10'd0, 32'd0, 3'd0);
      tests++; if (out_res !== 32'h7F800000) begin fails++; $display("FAIL ign_res: got %h want 7f800000", out_res); end
      tests++; if (out_exc !== 5'b01000) begin fails++; $display("FAIL ign_exc: got %b want 01000", out_exc); end
      tests++; if (status !== 5'b01000) begin fails++; $display("FAIL ign_status: got %b want 01000", status); end
      tests++; if (exc_cnt !== cnt_exp(1)) begin fails++; $display("FAIL ign_cnt: got %0d want %0d", exc_cnt, cnt_exp(1)); end
   endtask

   task automatic test_reset_midflight();
      int pulses;
      pulses = 0;
      op_valid = 1'b1; fpu_op = 2'd0;
      step();
      op_valid = 1'b1; fpu_op = 2'd3;
      step();
      op_valid = 1'b0; fpu_op = 2'd0;
      set_flags(F_B00, 32'h3F800000, 3'b001);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (out_valid !== 1'b0) pulses++;
         step();
         if (c == 0) set_flags(10'd0, 32'd0, 3'd0);
      end
      tests++; if (pulses != 0) begin fails++; $display("FAIL rstmid_pulses: got %0d want 0", pulses); end
      tests++; if (out_res !== 32'd0) begin fails++; $display("FAIL rstmid_res: got %h want 0", out_res); end
      tests++; if (out_exc !== 5'd0) begin fails++; $display("FAIL rstmid_exc: got %b want 0", out_exc); end
      tests++; if (status !== 5'd0) begin fails++; $display("FAIL rstmid_status: got %b want 0", status); end
      tests++; if (exc_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_cnt: got %0d want 0", exc_cnt); end
   endtask

   initial begin
      test_reset();
      test_resolve();
      test_back_to_back();
      test_clear_with_event();
      test_flags_ignored();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
